// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per functional unit,
// round-robin grant of one completed tag per cycle onto the CDB.
`ifndef PHYS_REG_BITS
`define PHYS_REG_BITS 6
`endif

module cdb_arbiter #(
    parameter int NUM_FU   = 4,
    parameter int TAG_BITS = `PHYS_REG_BITS
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_FU-1:0]          fu_valid,
    input  logic [NUM_FU*TAG_BITS-1:0] fu_tag,
    input  logic                       flush,
    output logic [NUM_FU-1:0]          fu_ready,
    output logic [TAG_BITS-1:0]        cdb_tag,
    output logic                       cdb_valid
);

    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [NUM_FU-1:0]   slot_valid;
    logic [TAG_BITS-1:0] slot_tag [NUM_FU];
    logic [PTR_W-1:0]    rr_ptr;

    logic [NUM_FU-1:0]   grant;
    logic [PTR_W-1:0]    gnt_idx;
    logic                gnt_any;
    logic [PTR_W-1:0]    ptr_next;

    // Grant depends only on registered slots, never on this cycle's FU inputs.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        if (!reset && !flush) begin
            for (int k = 0; k < NUM_FU; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NUM_FU) begin
                    idx = idx - NUM_FU;
                end
                if (!gnt_any && slot_valid[idx]) begin
                    gnt_any = 1'b1;
                    gnt_idx = idx[PTR_W-1:0];
                end
            end
        end
    end

    always_comb begin
        grant = '0;
        if (gnt_any) begin
            grant[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        fu_ready = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            fu_ready[i] = !reset && !flush && (!slot_valid[i] || grant[i]);
        end
    end

    always_comb begin
        ptr_next = rr_ptr;
        if (gnt_any) begin
            if (gnt_idx == PTR_W'(NUM_FU - 1)) begin
                ptr_next = '0;
            end else begin
                ptr_next = gnt_idx + 1'b1;
            end
        end
    end

    assign cdb_valid = gnt_any;
    assign cdb_tag   = gnt_any ? slot_tag[gnt_idx] : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            slot_valid <= '0;
            rr_ptr     <= '0;
            for (int i = 0; i < NUM_FU; i++) begin
                slot_tag[i] <= '0;
            end
        end else begin
            // A refill on the grant edge wins over the drain.
            for (int i = 0; i < NUM_FU; i++) begin
                if (flush) begin
                    slot_valid[i] <= 1'b0;
                end else if (fu_valid[i] && fu_ready[i]) begin
                    slot_valid[i] <= 1'b1;
                    slot_tag[i]   <= fu_tag[i*TAG_BITS +: TAG_BITS];
                end else if (grant[i]) begin
                    slot_valid[i] <= 1'b0;
                end
            end
            rr_ptr <= ptr_next;
        end
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_FU, default 4: number of functional-unit completion ports, legal range 2..8.
REQ-002 SHALL have parameter TAG_BITS, default `PHYS_REG_BITS: physical tag width.
REQ-003 SHALL have port clock  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port fu_valid  input  NUM_FU  bit i = FU i presents a completed tag.
REQ-006 SHALL have port fu_tag  input  NUM_FU*TAG_BITS  FU i tag at bits [i*TAG_BITS +: TAG_BITS].
REQ-007 SHALL have port flush  input  1  mispredict squash of all pending completions.
REQ-008 SHALL have port fu_ready  output  NUM_FU  bit i = slot i can accept this cycle.
REQ-009 SHALL have port cdb_tag  output  TAG_BITS  tag granted this cycle, to the CDB register input.
REQ-010 SHALL have port cdb_valid  output  1  grant valid, to the CDB register valid input.

Function
REQ-011 SHALL hold one slot per FU: slot_valid[i] plus slot_tag[i], both registered.
REQ-012 SHALL drive fu_ready[i] = !reset && !flush && (!slot_valid[i] || grant[i]), computed combinationally from registered state and flush only.
REQ-013 SHALL capture fu_tag i into slot i at the clock edge when fu_valid[i] && fu_ready[i]. fu_valid[i] with fu_ready[i]=0 SHALL be ignored; the FU holds its result.
REQ-014 SHALL grant at most one slot per cycle, round-robin: first valid slot scanning rr_ptr, rr_ptr+1, ... modulo NUM_FU.
REQ-015 SHALL form the grant only from registered slot state; no combinational path from fu_valid/fu_tag to cdb_tag/cdb_valid.
REQ-016 SHALL drive cdb_valid=1 and cdb_tag=slot_tag[g] when slot g is granted. Otherwise cdb_valid=0 and cdb_tag=0.
REQ-017 SHALL, on a grant of slot g, set rr_ptr to (g+1) mod NUM_FU at the edge. rr_ptr SHALL be unchanged without a grant.
REQ-018 SHALL clear slot_valid[g] at the edge after a grant, unless a new capture into slot g occurs that same edge. Same-edge drain and refill SHALL leave slot g valid with the new tag.
REQ-019 SHALL give capture-to-broadcast latency of 1 cycle minimum: FU i accepted at edge t, earliest cdb_valid in cycle t..t+1.
REQ-020 SHALL guarantee a pending slot waits at most NUM_FU-1 grant cycles (starvation-free).
REQ-021 SHALL, while flush=1, force cdb_valid=0, cdb_tag=0, fu_ready=0, and make no grant. All slot_valid SHALL clear at that edge. rr_ptr SHALL be unchanged.
REQ-022 SHALL accept all NUM_FU ports simultaneously; each accepted result occupies its own slot, and no result is dropped or duplicated.
REQ-023 SHALL retain slot_tag contents when a slot is invalid; those contents SHALL never drive cdb_tag.

Reset
REQ-024 SHALL, at a clock edge with reset=1, clear all slot_valid, all slot_tag to 0, and rr_ptr to 0.
REQ-025 SHALL, while reset=1, drive cdb_valid=0, cdb_tag=0, fu_ready=0 and ignore fu_valid/flush.
REQ-026 SHALL treat reset mid-operation the same: pending slots are discarded with no broadcast. The first cycle after deassert SHALL show fu_ready all 1 and cdb_valid=0.

Verification (NUM_FU=4, TAG_BITS=6)
REQ-027 SHALL cover single result: FU2 valid tag 6'd17 for one cycle -> next cycle cdb_valid=1, cdb_tag=17, then rr_ptr=3 and cdb_valid=0.
REQ-028 SHALL cover simultaneous results: all FUs valid in one cycle, tags 5,9,12,33, rr_ptr=0 -> broadcasts 5,9,12,33 on consecutive cycles, each exactly once.
REQ-029 SHALL cover backpressure: FU0 asserts valid every cycle with tags 1,2,3 while FU1 slot is also pending -> fu_ready[0] drops while slot0 awaits grant, and the CDB sequence contains 1,2,3 in order with none lost.
REQ-030 SHALL cover same-edge drain/refill: slot1 holds 7 and is granted while FU1 offers 8 -> cdb_tag=7 this cycle and slot1 valid with 8 next cycle.
REQ-031 SHALL cover flush: slots 0 and 3 pending (tags 4,40), flush=1 one cycle -> cdb_valid=0 that cycle, no later broadcast of 4 or 40, rr_ptr unchanged.
REQ-032 SHALL cover reset mid-operation: three slots pending, reset=1 one cycle -> cdb_valid=0, then fu_ready=4'b1111 and rr_ptr=0 after deassert.
